// File: rtl/memref_pkg.sv
// Shared helpers for the memref_mp multi-port memory model: counter width,
// saturating add and popcount over up to MAX_PORTS enables.
package memref_pkg;

    localparam int unsigned CNT_W     = 32;
    localparam int unsigned MAX_PORTS = 32;

    // Adds inc to cnt, pinning at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [CNT_W-1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {1'b0, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_PORTS-1:0] vec);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            n = n + CNT_W'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/memref_rd_pipe.sv
// Per-read-port latency pipeline: valid bits shift every cycle, data only
// advances with a valid beat so the last stage holds the most recent result.
module memref_rd_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [LAT-1:0]   valid_q;
    logic [LAT-1:0]   valid_d;
    logic [WIDTH-1:0] data_q [LAT];
    logic [WIDTH-1:0] data_d [LAT];

    always_comb begin
        valid_d = '0;
        for (int unsigned k = 0; k < LAT; k++) begin
            data_d[k] = data_q[k];
        end
        valid_d[0] = in_valid;
        if (in_valid) begin
            data_d[0] = in_data;
        end
        for (int unsigned k = 1; k < LAT; k++) begin
            valid_d[k] = valid_q[k-1];
            if (valid_q[k-1]) begin
                data_d[k] = data_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < LAT; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int unsigned k = 0; k < LAT; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_data  = data_q[LAT-1];

endmodule

// File: rtl/memref_mp.sv
// Multi-port read-first memory model with per-port read latency, write-conflict
// detection and saturating access counters. MEMREF_MP_OOB_CHECK_EN adds oob_err.
module memref_mp
    import memref_pkg::*;
#(
    parameter  int unsigned WIDTH      = 32,
    parameter  int unsigned SIZE       = 8,
    parameter  int unsigned NUM_WR     = 1,
    parameter  int unsigned NUM_RD     = 2,
    parameter  int unsigned RD_LATENCY = 1,
    localparam int unsigned AW         = $clog2(SIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_WR-1:0]       wr_en,
    input  logic [NUM_WR*AW-1:0]    wr_addr,
    input  logic [NUM_WR*WIDTH-1:0] wr_data,
    input  logic [NUM_RD-1:0]       rd_en,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD-1:0]       rd_valid,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic                    wr_conflict,
    output logic [CNT_W-1:0]        wr_count,
    output logic [CNT_W-1:0]        rd_count
`ifdef MEMREF_MP_OOB_CHECK_EN
    ,
    output logic                    oob_err
`endif
);

    localparam logic [AW:0] SIZE_W = (AW+1)'(SIZE);

    logic [WIDTH-1:0] mem_q [SIZE];
    logic [SIZE-1:0]  mem_we;
    logic [WIDTH-1:0] mem_wdata [SIZE];

    logic [NUM_WR-1:0] wr_inr;
    logic [NUM_WR-1:0] wr_acc;
    logic [NUM_RD-1:0] rd_inr;
    logic [WIDTH-1:0]  rd_sample [NUM_RD];

    logic              wr_conflict_q, wr_conflict_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;
    logic [CNT_W-1:0]  rd_count_q, rd_count_d;

    // Write decode: ports are scanned low to high so the highest index wins a shared word.
    always_comb begin
        mem_we        = '0;
        wr_inr        = '0;
        wr_acc        = '0;
        wr_conflict_d = wr_conflict_q;
        for (int unsigned w = 0; w < SIZE; w++) begin
            mem_wdata[w] = '0;
        end
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            wr_inr[i] = {1'b0, wr_addr[i*AW +: AW]} < SIZE_W;
            wr_acc[i] = wr_en[i] && wr_inr[i];
            if (wr_acc[i]) begin
                mem_we[wr_addr[i*AW +: AW]]    = 1'b1;
                mem_wdata[wr_addr[i*AW +: AW]] = wr_data[i*WIDTH +: WIDTH];
            end
        end
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            for (int unsigned j = i + 1; j < NUM_WR; j++) begin
                if (wr_acc[i] && wr_acc[j] &&
                    (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW])) begin
                    wr_conflict_d = 1'b1;
                end
            end
        end
        wr_count_d = sat_add(wr_count_q, popcount(MAX_PORTS'(wr_acc)));
        rd_count_d = sat_add(rd_count_q, popcount(MAX_PORTS'(rd_en)));
    end

    // Read sampling sees the array before this edge's writes land.
    always_comb begin
        rd_inr = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            rd_inr[p]    = {1'b0, rd_addr[p*AW +: AW]} < SIZE_W;
            rd_sample[p] = '0;
            if (rd_en[p] && rd_inr[p]) begin
                rd_sample[p] = mem_q[rd_addr[p*AW +: AW]];
            end
`ifdef MEMREF_MP_OOB_CHECK_EN
            else if (rd_en[p]) begin
                rd_sample[p] = 'x;
            end
`endif
        end
    end

    // Storage is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned w = 0; w < SIZE; w++) begin
                if (mem_we[w]) begin
                    mem_q[w] <= mem_wdata[w];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_conflict_q <= 1'b0;
            wr_count_q    <= '0;
            rd_count_q    <= '0;
        end else begin
            wr_conflict_q <= wr_conflict_d;
            wr_count_q    <= wr_count_d;
            rd_count_q    <= rd_count_d;
        end
    end

    assign wr_conflict = wr_conflict_q;
    assign wr_count    = wr_count_q;
    assign rd_count    = rd_count_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        memref_rd_pipe #(
            .WIDTH (WIDTH),
            .LAT   (RD_LATENCY)
        ) u_rd_pipe (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (rd_en[p]),
            .in_data   (rd_sample[p]),
            .out_valid (rd_valid[p]),
            .out_data  (rd_data[p*WIDTH +: WIDTH])
        );
    end

`ifdef MEMREF_MP_OOB_CHECK_EN
    logic [NUM_WR-1:0] wr_oob;
    logic [NUM_RD-1:0] rd_oob;
    logic              oob_err_q, oob_err_d;

    always_comb begin
        wr_oob    = wr_en & ~wr_inr;
        rd_oob    = rd_en & ~rd_inr;
        oob_err_d = oob_err_q | (|wr_oob) | (|rd_oob);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oob_err_q <= 1'b0;
        end else begin
            oob_err_q <= oob_err_d;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_WR; i++) begin
                if (wr_oob[i]) begin
                    $error("memref_mp: write port %0d address %0d out of range", i, wr_addr[i*AW +: AW]);
                end
            end
            for (int unsigned p = 0; p < NUM_RD; p++) begin
                if (rd_oob[p]) begin
                    $error("memref_mp: read port %0d address %0d out of range", p, rd_addr[p*AW +: AW]);
                end
            end
        end
    end

    assign oob_err = oob_err_q;
`endif

endmodule

// File: tb/tb_memref_mp.sv
// Randomised + directed bench for memref_mp against a transaction-level model
// (array memory, queue of pending read results keyed by due cycle).
module tb_memref_mp;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned SIZE   = 6;
    localparam int unsigned NUM_WR = 2;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned LAT    = 4;
    localparam int unsigned AW     = $clog2(SIZE);
    localparam longint unsigned CNT_MAX = 64'h0000_0000_FFFF_FFFF;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_WR-1:0]       wr_en;
    logic [NUM_WR*AW-1:0]    wr_addr;
    logic [NUM_WR*WIDTH-1:0] wr_data;
    logic [NUM_RD-1:0]       rd_en;
    logic [NUM_RD*AW-1:0]    rd_addr;
    logic [NUM_RD-1:0]       rd_valid;
    logic [NUM_RD*WIDTH-1:0] rd_data;
    logic                    wr_conflict;
    logic [31:0]             wr_count;
    logic [31:0]             rd_count;
`ifdef MEMREF_MP_OOB_CHECK_EN
    logic                    oob_err;
`endif

    always #5 clk = ~clk;

    memref_mp #(
        .WIDTH      (WIDTH),
        .SIZE       (SIZE),
        .NUM_WR     (NUM_WR),
        .NUM_RD     (NUM_RD),
        .RD_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .wr_conflict (wr_conflict),
        .wr_count    (wr_count),
        .rd_count    (rd_count)
`ifdef MEMREF_MP_OOB_CHECK_EN
        ,
        .oob_err     (oob_err)
`endif
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {
        int unsigned      due;
        int unsigned      port;
        logic [WIDTH-1:0] data;
        bit               unk;
    } rd_rec_t;

    rd_rec_t          pend[$];
    logic [WIDTH-1:0] mem_m [SIZE];
    logic [WIDTH-1:0] hold_m [NUM_RD];
    bit               hold_unk [NUM_RD];
    bit               conflict_m;
    longint unsigned  wr_cnt_m, rd_cnt_m;
    int unsigned      cyc = 0;

    task automatic model_edge();
        int unsigned      nrd;
        int unsigned      nwr;
        int unsigned      a;
        rd_rec_t          rec;
        cyc++;
        if (rst) begin
            pend.delete();
            for (int p = 0; p < NUM_RD; p++) begin
                hold_m[p]   = '0;
                hold_unk[p] = 1'b0;
            end
            conflict_m = 1'b0;
            wr_cnt_m   = 0;
            rd_cnt_m   = 0;
            return;
        end
        nrd = 0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rd_en[p]) begin
                a        = int'(rd_addr[p*AW +: AW]);
                rec.due  = cyc + LAT - 1;
                rec.port = p;
                rec.unk  = 1'b0;
                if (a < SIZE) begin
                    rec.data = mem_m[a];
                end else begin
                    rec.data = '0;
`ifdef MEMREF_MP_OOB_CHECK_EN
                    rec.unk = 1'b1;
`endif
                end
                pend.push_back(rec);
                nrd++;
            end
        end
        rd_cnt_m = (rd_cnt_m + nrd > CNT_MAX) ? CNT_MAX : rd_cnt_m + nrd;
        nwr = 0;
        for (int i = 0; i < NUM_WR; i++) begin
            a = int'(wr_addr[i*AW +: AW]);
            if (wr_en[i] && a < SIZE) begin
                nwr++;
                for (int j = 0; j < i; j++) begin
                    if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) conflict_m = 1'b1;
                end
                mem_m[a] = wr_data[i*WIDTH +: WIDTH];
            end
        end
        wr_cnt_m = (wr_cnt_m + nwr > CNT_MAX) ? CNT_MAX : wr_cnt_m + nwr;
    endtask

    task automatic check_outputs();
        int  hit;
        bit  ev;
        for (int p = 0; p < NUM_RD; p++) begin
            hit = -1;
            ev  = 1'b0;
            foreach (pend[k]) begin
                if (pend[k].port == p && pend[k].due == cyc) hit = k;
            end
            if (hit >= 0) begin
                ev          = 1'b1;
                hold_m[p]   = pend[hit].data;
                hold_unk[p] = pend[hit].unk;
                pend.delete(hit);
            end
            check($sformatf("rd_valid[%0d]", p), 64'(rd_valid[p]), 64'(ev));
            if (!hold_unk[p]) begin
                check($sformatf("rd_data[%0d]", p), 64'(rd_data[p*WIDTH +: WIDTH]), 64'(hold_m[p]));
            end
        end
        check("wr_conflict", 64'(wr_conflict), 64'(conflict_m));
        check("wr_count", 64'(wr_count), wr_cnt_m);
        check("rd_count", 64'(rd_count), rd_cnt_m);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        rst   = 1'b0;
        wr_en = '0;
        rd_en = '0;
    endtask

    int unsigned lat;
    int unsigned nv;
    logic [WIDTH-1:0] v;

    initial begin
        rst     = 1'b1;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = '0;
        rd_addr = '0;
        for (int i = 0; i < SIZE; i++) begin
            v = $urandom;
            dut.mem_q[i] <= v;
            mem_m[i] = v;
        end
        conflict_m = 1'b0;
        wr_cnt_m   = 0;
        rd_cnt_m   = 0;
        for (int p = 0; p < NUM_RD; p++) begin
            hold_m[p]   = '0;
            hold_unk[p] = 1'b0;
        end

        repeat (3) tick();
        check("reset_rd_valid", 64'(rd_valid), 64'(0));
        check("reset_rd_data", 64'(rd_data), 64'(0));
        check("reset_wr_conflict", 64'(wr_conflict), 64'(0));
        check("reset_counts", {wr_count, rd_count}, 64'(0));
        idle();
        tick();

        // Write conflict: both ports hit word 3, port 1 must win.
        wr_en   = 2'b11;
        wr_addr = {AW'(3), AW'(3)};
        wr_data = {32'hBB, 32'hAA};
        tick();
        idle();
        repeat (100) tick();
        check("conflict_mem3", 64'(dut.mem_q[3]), 64'(32'hBB));
        check("conflict_sticky", 64'(wr_conflict), 64'(1));
        check("conflict_wr_count", 64'(wr_count), 64'(2));

        // Latency of a single read.
        dut.mem_q[5] <= 32'hA5A5_0005;
        mem_m[5] = 32'hA5A5_0005;
        rd_en   = 2'b01;
        rd_addr = {AW'(0), AW'(5)};
        tick();
        idle();
        lat = 1;
        while (!rd_valid[0] && lat < 20) begin
            tick();
            lat++;
        end
        check("rd_latency", 64'(lat), 64'(LAT));
        check("rd_latency_data", 64'(rd_data[WIDTH-1:0]), 64'(32'hA5A5_0005));
        repeat (3) tick();

        // Read-first: same-edge write is invisible, next read sees it.
        dut.mem_q[2] <= 32'h2222;
        mem_m[2] = 32'h2222;
        wr_en   = 2'b01;
        wr_addr = {AW'(0), AW'(2)};
        wr_data = {32'h0, 32'h1111};
        rd_en   = 2'b01;
        rd_addr = {AW'(0), AW'(2)};
        tick();
        wr_en = '0;
        tick();
        idle();
        repeat (LAT - 2) tick();
        check("read_first_old", 64'(rd_data[WIDTH-1:0]), 64'(32'h2222));
        tick();
        check("read_first_new", 64'(rd_data[WIDTH-1:0]), 64'(32'h1111));
        repeat (3) tick();

        // Out-of-range write then read of address 7.
        wr_en   = 2'b01;
        wr_addr = {AW'(0), AW'(7)};
        wr_data = {32'h0, 32'hDEAD_BEEF};
        tick();
        idle();
        rd_en   = 2'b01;
        rd_addr = {AW'(0), AW'(7)};
        tick();
        idle();
        repeat (LAT - 1) tick();
        check("oob_rd_valid", 64'(rd_valid[0]), 64'(1));
`ifdef MEMREF_MP_OOB_CHECK_EN
        check("oob_err", 64'(oob_err), 64'(1));
`else
        check("oob_rd_data", 64'(rd_data[WIDTH-1:0]), 64'(0));
`endif
        for (int i = 0; i < SIZE; i++) begin
            check($sformatf("oob_mem[%0d]", i), 64'(dut.mem_q[i]), 64'(mem_m[i]));
        end
        repeat (3) tick();

        // Reset while reads are in flight.
        nv = 0;
        for (int k = 0; k < 3; k++) begin
            rd_en   = 2'b11;
            rd_addr = {AW'($urandom_range(0, SIZE-1)), AW'($urandom_range(0, SIZE-1))};
            tick();
            nv += int'(rd_valid[0]) + int'(rd_valid[1]);
        end
        idle();
        rst = 1'b1;
        tick();
        nv += int'(rd_valid[0]) + int'(rd_valid[1]);
        idle();
        for (int k = 0; k < LAT + 4; k++) begin
            tick();
            nv += int'(rd_valid[0]) + int'(rd_valid[1]);
        end
        check("flush_no_valid", 64'(nv), 64'(0));
        check("flush_rd_count", 64'(rd_count), 64'(0));

        // Saturation of rd_count.
        dut.rd_count_q <= 32'hFFFF_FFFE;
        rd_cnt_m = 64'hFFFF_FFFE;
        rd_en   = 2'b11;
        rd_addr = {AW'(1), AW'(0)};
        repeat (2) tick();
        idle();
        check("rd_count_sat", 64'(rd_count), 64'(32'hFFFF_FFFF));
        tick();
        check("rd_count_sat_hold", 64'(rd_count), 64'(32'hFFFF_FFFF));

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NUM_WR; i++) begin
                wr_en[i] = $urandom_range(0, 1);
`ifdef MEMREF_MP_OOB_CHECK_EN
                wr_addr[i*AW +: AW] = AW'($urandom_range(0, SIZE-1));
`else
                wr_addr[i*AW +: AW] = AW'($urandom_range(0, (1 << AW) - 1));
`endif
                wr_data[i*WIDTH +: WIDTH] = $urandom;
            end
            for (int p = 0; p < NUM_RD; p++) begin
                rd_en[p] = $urandom_range(0, 1);
`ifdef MEMREF_MP_OOB_CHECK_EN
                rd_addr[p*AW +: AW] = AW'($urandom_range(0, SIZE-1));
`else
                rd_addr[p*AW +: AW] = AW'($urandom_range(0, (1 << AW) - 1));
`endif
            end
            tick();
        end
        idle();
        repeat (LAT + 2) tick();
        for (int i = 0; i < SIZE; i++) begin
            check($sformatf("final_mem[%0d]", i), 64'(dut.mem_q[i]), 64'(mem_m[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
